fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, address of the first fetched instruction after reset.
REQ-002 Parameter IMEM_SIZE, default 1024, instruction memory size in bytes, power of two.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard unit hold request; freezes PC and IF/ID register.
REQ-006 redirect_valid  input  1  resolved branch from a later stage; forces the next PC and squashes IF/ID.
REQ-007 redirect_target  input  64  byte address loaded into PC when redirect_valid=1.
REQ-008 imem_addr  output  64  byte address presented to instruction memory; combinationally equal to the PC register.
REQ-009 imem_instr  input  32  instruction word returned combinationally by instruction memory for imem_addr.
REQ-010 ifid_pc  output  64  PC of the instruction held in the IF/ID register.
REQ-011 ifid_instr  output  32  instruction held in the IF/ID register.
REQ-012 ifid_valid  output  1  IF/ID contents are a real instruction; 0 = bubble.
REQ-013 fetch_fault  output  1  sticky flag: PC was misaligned or out of bounds.
REQ-014 fetch_count  output  32  number of instructions delivered into IF/ID with valid=1 since reset.

Function
REQ-015 Next-PC priority SHALL be: reset > fault > redirect_valid > stall > early branch > PC+4.
REQ-016 fault condition: PC[1:0]!=0 or PC+3 >= IMEM_SIZE (evaluated on current PC); on the fault edge, fetch_fault SHALL set and PC SHALL hold thereafter.
REQ-017 While fetch_fault=1, ifid_valid SHALL load 0 every cycle and fetch_count SHALL not increment; redirect and stall are ignored.
REQ-018 redirect_valid=1 (no fault) SHALL load PC<=redirect_target and ifid_valid<=0 in the same edge, even when stall=1.
REQ-019 stall=1 (no redirect, no fault) SHALL hold PC, ifid_pc, ifid_instr, ifid_valid and fetch_count unchanged.
REQ-020 Otherwise IF/ID SHALL load ifid_pc<=PC, ifid_instr<=imem_instr, ifid_valid<=1, and fetch_count SHALL increment by 1.
REQ-021 Early branch: if imem_instr[31:26] is 6'b000101 (B) or 6'b100101 (BL), next PC SHALL be PC + (sign-extended imm26 << 2); else PC+4.
REQ-022 B/BL instructions SHALL still enter IF/ID with ifid_valid=1 (BL needs X30 write downstream).
REQ-023 Latency: instruction at PC appears on ifid_* one edge after PC is presented, absent stall/redirect/fault.
REQ-024 All PC arithmetic SHALL be 64-bit modulo 2^64; a wrapped result is then caught by REQ-016.
REQ-025 fetch_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-026 imem_instr SHALL be ignored (not decoded for early branch) when fault condition is true, as it may be X.

Reset
REQ-027 On reset=1 at posedge: PC<=RESET_PC, ifid_pc<=0, ifid_instr<=0, ifid_valid<=0, fetch_fault<=0, fetch_count<=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL take priority; stall and redirect in that cycle have no effect.
REQ-029 First valid IF/ID entry SHALL appear on the first posedge after the reset-deasserted edge (ifid_pc=RESET_PC).

Structure
REQ-030 Shared package cpu_pkg SHALL hold OPC_B (6'b000101), OPC_BL (6'b100101) and the 64-bit address typedef.
REQ-031 The IF/ID pipeline register (pc, instr, valid, with load/squash controls) SHALL be a separate sub-module ifid_reg.
REQ-032 Next-PC selection and fault detection SHALL be combinational inside fetch_stage; only PC, fault, count and ifid_reg are sequential.

Verification
REQ-033 Reset, memory of 4 ADDI words, no stall -> ifid_pc sequence 0,4,8,12 on consecutive edges, fetch_count=4.
REQ-034 PC=8 with B imm26=3 -> next PC=20 (8+12); B at pc 8 delivered with ifid_valid=1.
REQ-035 stall=1 for 3 cycles at PC=12 -> PC, ifid_* and fetch_count unchanged for 3 edges, resume at 16.
REQ-036 stall=1 and redirect_valid=1, target=40 same cycle -> PC=40, ifid_valid=0 next edge; ifid_pc=40 one edge later.
REQ-037 redirect_target=1022 -> fetch_fault=1 next edge, ifid_valid=0 and fetch_count frozen thereafter until reset; B imm26=-1 at PC=0 -> wrap, fault.
REQ-038 reset asserted during active stream at PC=24 -> next edge PC=0, all outputs at REQ-027 values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address type, early-branch opcodes and decode helpers.
package cpu_pkg;

  typedef logic [63:0] addr_t;

  localparam logic [5:0] OPC_B  = 6'b000101;
  localparam logic [5:0] OPC_BL = 6'b100101;

  // True for the unconditional immediate branches resolved in fetch.
  function automatic logic is_early_branch(input logic [31:0] instr);
    return (instr[31:26] == OPC_B) || (instr[31:26] == OPC_BL);
  endfunction

  // Sign-extended imm26 scaled to a byte offset.
  function automatic addr_t branch_offset(input logic [31:0] instr);
    return {{36{instr[25]}}, instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: squash clears valid only, load captures a new instruction,
// neither holds the current contents.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        squash,
  input  addr_t       next_pc,
  input  logic [31:0] next_instr,
  output addr_t       pc,
  output logic [31:0] instr,
  output logic        valid
);

  // Squash beats load so a redirect or fault never lets a wrong-path word through.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      instr <= '0;
      valid <= 1'b0;
    end else if (squash) begin
      valid <= 1'b0;
    end else if (load) begin
      pc    <= next_pc;
      instr <= next_instr;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection with early B/BL resolution,
// sticky fetch fault detection, delivered-instruction counter and the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          IMEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  addr_t       pc_reg;
  addr_t       pc_next;
  logic        fault_reg;
  logic [31:0] count_reg;
  logic        fault_cond;
  logic        load;
  logic        squash;

  assign imem_addr   = pc_reg;
  assign fetch_fault = fault_reg;
  assign fetch_count = count_reg;

  // Next-PC priority: fault > redirect > stall > early branch > PC+4.
  // imem_instr is only decoded on the load path, so a faulting PC never looks at it.
  always_comb begin
    fault_cond = (pc_reg[1:0] != 2'b00) || ((pc_reg + 64'd3) >= 64'(IMEM_SIZE));
    pc_next    = pc_reg;
    load       = 1'b0;
    squash     = 1'b0;
    if (fault_cond || fault_reg) begin
      squash = 1'b1;
    end else if (redirect_valid) begin
      pc_next = redirect_target;
      squash  = 1'b1;
    end else if (!stall) begin
      load = 1'b1;
      if (is_early_branch(imem_instr)) begin
        pc_next = pc_reg + branch_offset(imem_instr);
      end else begin
        pc_next = pc_reg + 64'd4;
      end
    end
  end

  // PC, sticky fault flag and delivered-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      fault_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      if (fault_cond) begin
        fault_reg <= 1'b1;
      end
      if (load) begin
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .squash     (squash),
    .next_pc    (pc_reg),
    .next_instr (imem_instr),
    .pc         (ifid_pc),
    .instr      (ifid_instr),
    .valid      (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized stall/redirect/reset traffic against a behavioural model.
module tb_fetch_stage;

  localparam int MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:MEM_WORDS-1];

  int total = 0;
  int bad   = 0;

  // Behavioural model state: what the outputs must show after the latest edge.
  logic [63:0] m_pc;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  logic [31:0] m_count;
  logic        m_valid;
  logic        m_fault;
  logic        m_known = 1'b0;

  always #5 clk = ~clk;

  // Instruction memory; outside the array it returns a B word that must be ignored.
  assign imem_instr = (imem_addr < 64'd1024) ? mem[imem_addr[9:2]] : 32'h14000001;

  fetch_stage #(.RESET_PC(64'h0), .IMEM_SIZE(1024)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .ifid_pc         (ifid_pc),
    .ifid_instr      (ifid_instr),
    .ifid_valid      (ifid_valid),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_addi();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h91000000 | 32'(i);
  endtask

  task automatic fill_random();
    logic [31:0] w;
    int          imm;
    for (int i = 0; i < MEM_WORDS; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        imm = int'($urandom_range(0, 12)) - 6;
        w = {($urandom_range(0, 1) == 1) ? 6'b100101 : 6'b000101, 26'(imm)};
      end else begin
        w = $urandom;
        if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) w[30] = ~w[30];
      end
      mem[i] = w;
    end
  endtask

  // Compare on the falling edge, then advance the model by the inputs the next rising edge will see.
  initial begin : model_proc
    logic [31:0] w;
    longint      off;
    forever begin
      @(negedge clk);
      if (m_known) begin
        chk("imem_addr",   imem_addr,          m_pc);
        chk("ifid_valid",  64'(ifid_valid),    64'(m_valid));
        chk("fetch_fault", 64'(fetch_fault),   64'(m_fault));
        chk("fetch_count", 64'(fetch_count),   64'(m_count));
        chk("ifid_pc",     ifid_pc,            m_ipc);
        chk("ifid_instr",  64'(ifid_instr),    64'(m_instr));
      end
      if (reset) begin
        m_pc = 64'd0; m_ipc = 64'd0; m_instr = 32'd0;
        m_valid = 1'b0; m_fault = 1'b0; m_count = 32'd0; m_known = 1'b1;
      end else if (m_known) begin
        if (m_fault || m_pc[1:0] != 2'b00 || m_pc > 64'd1020) begin
          m_fault = 1'b1;
          m_valid = 1'b0;
        end else if (redirect_valid) begin
          m_pc = redirect_target;
          m_valid = 1'b0;
        end else if (!stall) begin
          w = mem[int'(m_pc >> 2)];
          m_ipc = m_pc;
          m_instr = w;
          m_valid = 1'b1;
          m_count = m_count + 32'd1;
          if (w[31:26] == 6'b000101 || w[31:26] == 6'b100101) begin
            off = longint'($signed(w[25:0])) * 4;
            m_pc = m_pc + 64'(off);
          end else begin
            m_pc = m_pc + 64'd4;
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 64'd0;
    fill_addi();
    tick(); tick();
    chk("rst imem_addr", imem_addr, 64'd0);
    chk("rst ifid_valid", 64'(ifid_valid), 64'd0);
    chk("rst fetch_count", 64'(fetch_count), 64'd0);
    reset = 1'b0;

    // Straight-line fetch: 0,4,8 on consecutive edges.
    tick(); chk("seq ifid_pc0", ifid_pc, 64'd0); chk("seq valid0", 64'(ifid_valid), 64'd1);
    tick(); chk("seq ifid_pc1", ifid_pc, 64'd4);
    tick(); chk("seq ifid_pc2", ifid_pc, 64'd8); chk("seq pc12", imem_addr, 64'd12);
    // Three stall edges at PC=12.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall pc", imem_addr, 64'd12);
      chk("stall ifid_pc", ifid_pc, 64'd8);
      chk("stall count", 64'(fetch_count), 64'd3);
    end
    stall = 1'b0;
    tick();
    chk("resume ifid_pc", ifid_pc, 64'd12);
    chk("resume count", 64'(fetch_count), 64'd4);
    chk("model count", 64'(m_count), 64'd4);
    chk("resume pc", imem_addr, 64'd16);

    // Redirect wins over a simultaneous stall.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 64'd40;
    tick();
    chk("redir pc", imem_addr, 64'd40); chk("redir valid", 64'(ifid_valid), 64'd0);
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    chk("redir ifid_pc", ifid_pc, 64'd40); chk("redir count", 64'(fetch_count), 64'd5);

    // Reset mid-stream at PC=24 beats stall and redirect.
    redirect_valid = 1'b1; redirect_target = 64'd20;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("pre-reset pc", imem_addr, 64'd24);
    reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 64'd100;
    tick();
    chk("mid rst pc", imem_addr, 64'd0);
    chk("mid rst ifid_pc", ifid_pc, 64'd0);
    chk("mid rst instr", 64'(ifid_instr), 64'd0);
    chk("mid rst valid", 64'(ifid_valid), 64'd0);
    chk("mid rst count", 64'(fetch_count), 64'd0);

    // Early branch: B imm26=3 at PC=8 -> 20.
    mem[2] = 32'h14000003;
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("b ifid_pc", ifid_pc, 64'd8);
    chk("b ifid_instr", 64'(ifid_instr), 64'h14000003);
    chk("b valid", 64'(ifid_valid), 64'd1);
    chk("b target", imem_addr, 64'd20);
    chk("model b target", m_pc, 64'd20);

    // Misaligned redirect faults; everything freezes afterwards.
    redirect_valid = 1'b1; redirect_target = 64'd1022;
    tick();
    chk("bad redir pc", imem_addr, 64'd1022); chk("bad redir fault", 64'(fetch_fault), 64'd0);
    redirect_target = 64'd0;
    tick();
    chk("fault set", 64'(fetch_fault), 64'd1);
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      tick();
      chk("fault pc hold", imem_addr, 64'd1022);
      chk("fault count", 64'(fetch_count), 64'd3);
      chk("fault valid", 64'(ifid_valid), 64'd0);
    end

    // B imm26=-1 at PC=0 wraps below zero and faults.
    reset = 1'b1; redirect_valid = 1'b0; stall = 1'b0;
    mem[0] = 32'h17FFFFFF; mem[2] = 32'h91000002;
    tick();
    reset = 1'b0;
    tick();
    chk("wrap ifid_instr", 64'(ifid_instr), 64'h17FFFFFF);
    chk("wrap pc", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap fault", 64'(fetch_fault), 64'd1);
    chk("wrap count", 64'(fetch_count), 64'd1);
    tick();
    chk("wrap pc hold", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // Randomized traffic against the model.
    reset = 1'b1;
    fill_random();
    tick();
    for (int c = 0; c < 3000; c++) begin
      if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        if ($urandom_range(0, 1) == 1) fill_random();
      end else begin
        reset = 1'b0;
      end
      stall = ($urandom_range(0, 5) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) redirect_target = 64'($urandom_range(0, 2047));
      else redirect_target = 64'($urandom_range(0, 255)) << 2;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
